// File: rtl/counter_share_arb.sv
// counter_share_arb: round-robin arbiter that lends one loadable up counter
// to NREQ requesters. A granted requester's start value is loaded, counted up
// to all-ones, and the run ends with a DONE pulse (or an ABRT pulse if the
// requester withdraws its request while counting).
module counter_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                    C,
    input  logic                    R,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ*WIDTH-1:0]   LDVAL,
    output logic [NREQ-1:0]         GNT,
    output logic [WIDTH-1:0]        Q,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ABRT
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW1 = IW + 1;
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [IW-1:0]     ptr_r, ptr_s;
    logic [IW-1:0]     gidx_r, gidx_s;
    logic [NREQ-1:0]   gnt_r, gnt_s;
    logic [WIDTH-1:0]  q_r, q_s;
    logic              done_r, done_s;
    logic              abrt_r, abrt_s;
    logic              busy_r, busy_s;

    logic              found_s;
    logic [IW-1:0]     pick_s;
    logic [IW1-1:0]    cand_s;
    logic [WIDTH-1:0]  ld_s;
    logic [IW-1:0]     ptr_nxt_s;

    // Index-to-one-hot conversion for the grant vector.
    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = {NREQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        found_s = 1'b0;
        pick_s  = ptr_r;
        cand_s  = {IW1{1'b0}};
        for (int off = 0; off < NREQ; off++) begin
            cand_s = {1'b0, ptr_r} + IW1'(off);
            if (cand_s >= IW1'(NREQ)) begin
                cand_s = cand_s - IW1'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && REQ[cand_s[IW-1:0]]) begin
                found_s = 1'b1;
                pick_s  = cand_s[IW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Start value of the currently granted requester.
    always_comb begin
        ld_s = {WIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (gidx_r == IW'(i)) begin
                ld_s = LDVAL[i*WIDTH +: WIDTH];
            end else begin
                ld_s = ld_s;
            end
        end
    end

    // Pointer moves one past the requester whose run just ended.
    always_comb begin
        if (gidx_r == IW'(NREQ - 1)) begin
            ptr_nxt_s = {IW{1'b0}};
        end else begin
            ptr_nxt_s = gidx_r + IW'(1);
        end
    end

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        gidx_s  = gidx_r;
        gnt_s   = gnt_r;
        q_s     = q_r;
        done_s  = 1'b0;
        abrt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    gidx_s  = pick_s;
                    gnt_s   = onehot(pick_s);
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                q_s     = ld_s;
                state_s = COUNT;
            end
            COUNT: begin
                if (!REQ[gidx_r]) begin
                    state_s = IDLE;
                    gnt_s   = {NREQ{1'b0}};
                    abrt_s  = 1'b1;
                    ptr_s   = ptr_nxt_s;
                end else if (q_r == MAX) begin
                    state_s = FIN;
                    done_s  = 1'b1;
                end else begin
                    q_s = q_r + WIDTH'(1);
                end
            end
            FIN: begin
                state_s = IDLE;
                gnt_s   = {NREQ{1'b0}};
                ptr_s   = ptr_nxt_s;
            end
            default: begin
                state_s = IDLE;
                gnt_s   = {NREQ{1'b0}};
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge C) begin
        if (R) begin
            state_r <= IDLE;
            ptr_r   <= {IW{1'b0}};
            gidx_r  <= {IW{1'b0}};
            gnt_r   <= {NREQ{1'b0}};
            q_r     <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
            abrt_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            gidx_r  <= gidx_s;
            gnt_r   <= gnt_s;
            q_r     <= q_s;
            done_r  <= done_s;
            abrt_r  <= abrt_s;
            busy_r  <= busy_s;
        end
    end

    assign GNT  = gnt_r;
    assign Q    = q_r;
    assign BUSY = busy_r;
    assign DONE = done_r;
    assign ABRT = abrt_r;

endmodule
